seg7_scan_ctrl: RTL

Memory-mapped controller for the SoC's eight-digit seven-segment display. It sits behind the CPU I/O bus decoder and holds the display data, digit-enable and decimal-point registers. It time-multiplexes the eight digits onto the shared segment lines `DN_A`..`DN_DP`, with a programmable per-digit dwell time and an inter-digit ghost-blanking gap.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_hex_decode.sv | 39 +++
 rtl/seg7_scan_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants for the seven-segment scan controller:
//             bus register offsets, MASK reset value, hex segment codes
//             ({G,F,E,D,C,B,A}, active-high) and the slot phase type.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Bus register map (wr_addr / rd_addr); offset 3 is reserved.
  localparam logic [1:0] SEG7_DATA = 2'd0;
  localparam logic [1:0] SEG7_MASK = 2'd1;
  localparam logic [1:0] SEG7_DP   = 2'd2;

  // All eight digits enabled out of reset.
  localparam logic [7:0] SEG7_MASK_RST = 8'hFF;

  // Hex glyphs, bit order {G,F,E,D,C,B,A}.
  localparam logic [6:0] SEG7_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG7_HEX_1 = 7'h06;
  localparam logic [6:0] SEG7_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG7_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG7_HEX_4 = 7'h66;
  localparam logic [6:0] SEG7_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG7_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG7_HEX_7 = 7'h07;
  localparam logic [6:0] SEG7_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG7_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG7_HEX_A = 7'h77;
  localparam logic [6:0] SEG7_HEX_B = 7'h7C;
  localparam logic [6:0] SEG7_HEX_C = 7'h39;
  localparam logic [6:0] SEG7_HEX_D = 7'h5E;
  localparam logic [6:0] SEG7_HEX_E = 7'h79;
  localparam logic [6:0] SEG7_HEX_F = 7'h71;

  // Each digit slot opens with a ghost-blanking gap, then shows the digit.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } seg7_phase_e;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decode
//  Purpose  : Combinational 4-bit nibble to seven-segment glyph decoder.
//  Ports    : i_nib [3:0]  nibble to display
//             o_seg [6:0]  segments {G,F,E,D,C,B,A}, active-high
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_nib)
      4'h0: o_seg = SEG7_HEX_0;
      4'h1: o_seg = SEG7_HEX_1;
      4'h2: o_seg = SEG7_HEX_2;
      4'h3: o_seg = SEG7_HEX_3;
      4'h4: o_seg = SEG7_HEX_4;
      4'h5: o_seg = SEG7_HEX_5;
      4'h6: o_seg = SEG7_HEX_6;
      4'h7: o_seg = SEG7_HEX_7;
      4'h8: o_seg = SEG7_HEX_8;
      4'h9: o_seg = SEG7_HEX_9;
      4'hA: o_seg = SEG7_HEX_A;
      4'hB: o_seg = SEG7_HEX_B;
      4'hC: o_seg = SEG7_HEX_C;
      4'hD: o_seg = SEG7_HEX_D;
      4'hE: o_seg = SEG7_HEX_E;
      default: o_seg = SEG7_HEX_F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Memory-mapped eight-digit seven-segment scan controller.
//             Holds DATA / MASK / DP registers and time-multiplexes the
//             digits onto shared segment lines, with a blank gap at the
//             start of every digit slot to suppress ghosting.
//  Params   : SCAN_DIV  clocks per digit slot (>= GHOST+2)
//             GHOST     blank clocks at the start of each slot
//  Ports    : fpga_clk, fpga_rst (async, active-high)
//             wr_en, wr_addr[1:0], wr_data[31:0]   register write port
//             rd_addr[1:0], rd_data[31:0]          registered readback
//             dig_en[7:0]                          digit anodes, one-hot/zero
//             DN_A..DN_G, DN_DP                    segments, active-high
//  Options  : SEG7_LZB_EN  defined -> leading-zero blanking on digits 7..1
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int GHOST    = 200
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [7:0]  dig_en,
  output logic        DN_A,
  output logic        DN_B,
  output logic        DN_C,
  output logic        DN_D,
  output logic        DN_E,
  output logic        DN_F,
  output logic        DN_G,
  output logic        DN_DP
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(GHOST);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_data;
  logic [7:0]       r_mask;
  logic [7:0]       r_dp;
  logic [31:0]      r_rd_data;
  logic [7:0]       r_dig_en;
  logic [6:0]       r_seg;
  logic             r_dp_out;

  seg7_phase_e      w_phase;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic             w_supp;
  logic             w_lit;
  logic [31:0]      w_rd_next;

  // --------------------------------------------------------------------------
  // Scan timebase: cnt walks the slot, idx steps to the next digit on wrap.
  // Bus writes never touch these, so a write cannot disturb slot timing.
  // --------------------------------------------------------------------------
  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Register file write port; offset 3 is silently dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      r_data <= 32'h0;
      r_mask <= SEG7_MASK_RST;
      r_dp   <= 8'h00;
    end else if (wr_en) begin
      case (wr_addr)
        SEG7_DATA: r_data <= wr_data;
        SEG7_MASK: r_mask <= wr_data[7:0];
        SEG7_DP:   r_dp   <= wr_data[7:0];
        default:   ;
      endcase
    end
  end

  // Readback mux samples the pre-write register value, so a same-cycle
  // read of a register being written returns the old contents.
  always_comb begin
    w_rd_next = 32'h0;
    case (rd_addr)
      SEG7_DATA: w_rd_next = r_data;
      SEG7_MASK: w_rd_next = {24'h0, r_mask};
      SEG7_DP:   w_rd_next = {24'h0, r_dp};
      default:   w_rd_next = 32'h0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Digit selection and decode.
  // --------------------------------------------------------------------------
  assign w_phase = (r_cnt < CNT_SHOW) ? PH_BLANK : PH_SHOW;
  assign w_nib   = r_data[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

`ifdef SEG7_LZB_EN
  // A digit is a leading zero when it and every more-significant nibble
  // are zero. Digit 0 always shows; a lit decimal point keeps the digit on.
  logic [7:0] w_lead_zero;
  assign w_lead_zero[0] = 1'b0;
  for (genvar gi = 1; gi < 8; gi++) begin : g_lead_zero
    assign w_lead_zero[gi] = ~|r_data[31:4*gi];
  end
  assign w_supp = w_lead_zero[r_idx] & ~r_dp[r_idx];
`else
  assign w_supp = 1'b0;
`endif

  assign w_lit = (w_phase == PH_SHOW) & r_mask[r_idx] & ~w_supp;

  // --------------------------------------------------------------------------
  // Output registers: every pin is a flop, one clock behind scan state.
  // --------------------------------------------------------------------------
  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      r_dig_en  <= 8'h00;
      r_seg     <= 7'h00;
      r_dp_out  <= 1'b0;
      r_rd_data <= 32'h0;
    end else begin
      r_dig_en  <= w_lit ? (8'h01 << r_idx) : 8'h00;
      r_seg     <= w_lit ? w_seg : 7'h00;
      r_dp_out  <= w_lit & r_dp[r_idx];
      r_rd_data <= w_rd_next;
    end
  end

  assign rd_data = r_rd_data;
  assign dig_en  = r_dig_en;
  assign {DN_G, DN_F, DN_E, DN_D, DN_C, DN_B, DN_A} = r_seg;
  assign DN_DP   = r_dp_out;

endmodule
`default_nettype wire
